// File: rtl/bloom_rotation_ctrl.sv
// Bucket rotation sequencer for the time-decaying bloom filter.
// Advances the insert bucket and sweeps the oldest bucket to zero.
module bloom_rotation_ctrl #(
  parameter int NUM_BUCKETS      = 4,
  parameter int BUCKET_ADDR_BITS = 10,
  localparam int BUCKET_BITS =
    (NUM_BUCKETS > 2) ? $clog2(NUM_BUCKETS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        update,
  input  logic                        enable,
  output logic [BUCKET_BITS-1:0]      cur_bucket,
  output logic                        clr_req,
  output logic [BUCKET_BITS-1:0]      clr_bucket,
  output logic [BUCKET_ADDR_BITS-1:0] clr_addr,
  input  logic                        clr_ack,
  output logic                        busy,
  output logic                        rotate_done,
  output logic [7:0]                  missed_count
);

  typedef enum logic [1:0] {
    IDLE,
    ROTATE,
    CLEAR,
    DONE
  } state_t;

  localparam logic [BUCKET_ADDR_BITS-1:0] LAST_ADDR = '1;
  localparam logic [BUCKET_BITS-1:0] LAST_BKT =
    BUCKET_BITS'(NUM_BUCKETS - 1);

  function automatic logic [BUCKET_BITS-1:0] next_bkt(
    input logic [BUCKET_BITS-1:0] b
  );
    return (b == LAST_BKT) ? '0 : b + 1'b1;
  endfunction

  state_t state;
  state_t state_nx;

  logic [BUCKET_BITS-1:0]      cur_nx;
  logic [BUCKET_BITS-1:0]      clr_bkt_nx;
  logic [BUCKET_ADDR_BITS-1:0] addr_nx;
  logic                        req_nx;
  logic                        busy_nx;
  logic                        done_nx;
  logic [7:0]                  missed_nx;

  logic start;
  logic last_ack;
  logic miss;

  assign start    = update && enable && (state == IDLE);
  assign last_ack = clr_ack && (clr_addr == LAST_ADDR);
  assign miss     = update && (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (start) state_nx = ROTATE;
      ROTATE: state_nx = CLEAR;
      CLEAR:  if (last_ack) state_nx = DONE;
      DONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cur_nx     = cur_bucket;
    clr_bkt_nx = clr_bucket;
    addr_nx    = clr_addr;
    req_nx     = clr_req;
    busy_nx    = busy;
    done_nx    = 1'b0;
    missed_nx  = missed_count;
    unique case (state)
      IDLE: begin
        if (start) busy_nx = 1'b1;
      end
      ROTATE: begin
        // oldest bucket is the one just past the new insert bucket
        cur_nx     = next_bkt(cur_bucket);
        clr_bkt_nx = next_bkt(next_bkt(cur_bucket));
        addr_nx    = '0;
        req_nx     = 1'b1;
      end
      CLEAR: begin
        if (last_ack) begin
          req_nx  = 1'b0;
          addr_nx = '0;
          done_nx = 1'b1;
        end else if (clr_ack) begin
          addr_nx = clr_addr + 1'b1;
        end
      end
      DONE: begin
        busy_nx = 1'b0;
      end
      default: begin
        req_nx  = 1'b0;
        busy_nx = 1'b0;
      end
    endcase
    if (miss && (missed_count != 8'hFF)) begin
      missed_nx = missed_count + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_bucket   <= '0;
      clr_bucket   <= '0;
      clr_addr     <= '0;
      clr_req      <= 1'b0;
      busy         <= 1'b0;
      rotate_done  <= 1'b0;
      missed_count <= '0;
    end else begin
      cur_bucket   <= cur_nx;
      clr_bucket   <= clr_bkt_nx;
      clr_addr     <= addr_nx;
      clr_req      <= req_nx;
      busy         <= busy_nx;
      rotate_done  <= done_nx;
      missed_count <= missed_nx;
    end
  end

endmodule

// File: tb/tb_bloom_rotation_ctrl.sv
// Bench for bloom_rotation_ctrl: vector table, write scoreboard
// and hand-written multi-cycle sequences.
module tb_bloom_rotation_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       update = 1'b0;
  logic       enable = 1'b0;
  logic       clr_ack = 1'b0;
  logic [1:0] cur_bucket;
  logic       clr_req;
  logic [1:0] clr_bucket;
  logic [2:0] clr_addr;
  logic       busy;
  logic       rotate_done;
  logic [7:0] missed_count;

  bloom_rotation_ctrl #(
    .NUM_BUCKETS(4),
    .BUCKET_ADDR_BITS(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .update(update),
    .enable(enable),
    .cur_bucket(cur_bucket),
    .clr_req(clr_req),
    .clr_bucket(clr_bucket),
    .clr_addr(clr_addr),
    .clr_ack(clr_ack),
    .busy(busy),
    .rotate_done(rotate_done),
    .missed_count(missed_count)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic upd;
    logic en;
    logic ack;
    int   cur;
    int   req;
    int   cb;
    int   addr;
    int   bsy;
    int   done;
    int   miss;
  } vec_t;

  typedef struct packed {
    logic [1:0] b;
    logic [2:0] a;
  } ent_t;

  vec_t tbl[11];
  ent_t sb[$];
  ent_t mon_e;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d, expected %0d", n, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sweep(input int b);
    for (int a = 0; a < 8; a++) begin
      sb.push_back(ent_t'{b: 2'(b), a: 3'(a)});
    end
  endtask

  task automatic pulse_update();
    update = 1'b1;
    tick();
    update = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    update = 1'b0;
    enable = 1'b1;
    clr_ack = 1'b0;
    sb.delete();
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input string n, input int max);
    int c;
    c = 0;
    while (busy && c < max) begin
      tick();
      c++;
    end
    chk(n, 32'(busy), 0);
  endtask

  // every accepted clear write must match the next expected one
  always @(negedge clk) begin
    if (reset && clr_req && clr_ack) begin
      if (sb.size() == 0) begin
        chk("sb_extra_write", 32'(clr_addr), 32'hFFFF_FFFF);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_bucket", 32'(clr_bucket), 32'(mon_e.b));
        chk("sb_addr", 32'(clr_addr), 32'(mon_e.a));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int c;
    int exp_addr;

    tbl[0] = '{1, 1, 1, 0, 0, -1, 0, 1, 0, 0};
    tbl[1] = '{0, 1, 1, 1, 1, 2, 0, 1, 0, 0};
    for (int k = 2; k <= 8; k++) begin
      tbl[k] = '{0, 1, 1, 1, 1, 2, k - 1, 1, 0, 0};
    end
    tbl[9]  = '{0, 1, 1, 1, 0, -1, 0, 1, 1, 0};
    tbl[10] = '{0, 1, 1, 1, 0, -1, 0, 0, 0, 0};

    // reset state
    tick();
    tick();
    chk("rst_cur", 32'(cur_bucket), 0);
    chk("rst_req", 32'(clr_req), 0);
    chk("rst_cb", 32'(clr_bucket), 0);
    chk("rst_addr", 32'(clr_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(rotate_done), 0);
    chk("rst_miss", 32'(missed_count), 0);
    reset = 1'b1;

    // 1: single rotation, ack tied high
    push_sweep(2);
    for (int i = 0; i < 11; i++) begin
      update  = tbl[i].upd;
      enable  = tbl[i].en;
      clr_ack = tbl[i].ack;
      tick();
      chk($sformatf("t1_cur_%0d", i), 32'(cur_bucket), tbl[i].cur);
      chk($sformatf("t1_req_%0d", i), 32'(clr_req), tbl[i].req);
      if (tbl[i].cb >= 0) begin
        chk($sformatf("t1_cb_%0d", i), 32'(clr_bucket), tbl[i].cb);
      end
      chk($sformatf("t1_addr_%0d", i), 32'(clr_addr), tbl[i].addr);
      chk($sformatf("t1_busy_%0d", i), 32'(busy), tbl[i].bsy);
      chk($sformatf("t1_done_%0d", i), 32'(rotate_done), tbl[i].done);
      chk($sformatf("t1_miss_%0d", i), 32'(missed_count), tbl[i].miss);
    end
    chk("t1_sb_empty", 32'(sb.size()), 0);

    // 2: four rotations, bucket wrap
    do_reset();
    clr_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_sweep((i + 2) % 4);
      pulse_update();
      tick();
      chk($sformatf("t2_cur_%0d", i), 32'(cur_bucket), (i + 1) % 4);
      chk($sformatf("t2_cb_%0d", i), 32'(clr_bucket), (i + 2) % 4);
      wait_idle($sformatf("t2_idle_%0d", i), 20);
    end
    chk("t2_sb_empty", 32'(sb.size()), 0);

    // 3: back-pressure, ack alternating
    do_reset();
    push_sweep(2);
    pulse_update();
    tick();
    chk("t3_req_start", 32'(clr_req), 1);
    c = 0;
    exp_addr = 0;
    while (clr_req && c < 40) begin
      clr_ack = c[0];
      c++;
      tick();
      if (clr_ack) exp_addr++;
      if (exp_addr < 8) begin
        chk($sformatf("t3_addr_%0d", c), 32'(clr_addr), exp_addr);
      end else begin
        chk("t3_done", 32'(rotate_done), 1);
      end
    end
    chk("t3_cycles", c, 16);
    clr_ack = 1'b0;
    wait_idle("t3_idle", 10);
    chk("t3_sb_empty", 32'(sb.size()), 0);

    // 4: missed pulses in CLEAR, ignored pulses in IDLE
    do_reset();
    push_sweep(2);
    pulse_update();
    tick();
    for (int i = 0; i < 3; i++) begin
      enable = (i == 1) ? 1'b0 : 1'b1;
      pulse_update();
      tick();
    end
    chk("t4_miss_clear", 32'(missed_count), 3);
    chk("t4_cur_clear", 32'(cur_bucket), 1);
    enable = 1'b1;
    clr_ack = 1'b1;
    wait_idle("t4_idle", 20);
    clr_ack = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pulse_update();
      tick();
    end
    chk("t4_busy_ign", 32'(busy), 0);
    chk("t4_req_ign", 32'(clr_req), 0);
    chk("t4_miss_ign", 32'(missed_count), 3);
    chk("t4_cur_ign", 32'(cur_bucket), 1);
    chk("t4_sb_empty", 32'(sb.size()), 0);

    // 5: saturation of missed_count
    do_reset();
    push_sweep(2);
    pulse_update();
    tick();
    for (int i = 0; i < 300; i++) begin
      pulse_update();
      tick();
      if (i == 9) chk("t5_miss_10", 32'(missed_count), 10);
      if (i == 254) chk("t5_miss_255", 32'(missed_count), 255);
    end
    chk("t5_miss_sat", 32'(missed_count), 255);
    chk("t5_addr_stall", 32'(clr_addr), 0);
    clr_ack = 1'b1;
    wait_idle("t5_idle", 20);
    chk("t5_sb_empty", 32'(sb.size()), 0);

    // 6: asynchronous reset mid-sweep
    do_reset();
    clr_ack = 1'b1;
    push_sweep(2);
    pulse_update();
    tick();
    c = 0;
    while (!(clr_req && clr_addr == 3'd4) && c < 20) begin
      tick();
      c++;
    end
    chk("t6_reach4", 32'(clr_addr), 4);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_cur", 32'(cur_bucket), 0);
    chk("t6_req", 32'(clr_req), 0);
    chk("t6_cb", 32'(clr_bucket), 0);
    chk("t6_addr", 32'(clr_addr), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_done", 32'(rotate_done), 0);
    chk("t6_miss", 32'(missed_count), 0);
    sb.delete();
    tick();
    reset = 1'b1;
    tick();
    tick();
    chk("t6_no_resume", 32'(busy), 0);
    push_sweep(2);
    pulse_update();
    tick();
    chk("t6_new_cur", 32'(cur_bucket), 1);
    chk("t6_new_cb", 32'(clr_bucket), 2);
    chk("t6_new_addr", 32'(clr_addr), 0);
    chk("t6_new_req", 32'(clr_req), 1);
    wait_idle("t6_idle", 20);
    chk("t6_sb_empty", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bloom_rotation_ctrl.md
Name: bloom_rotation_ctrl

Overview:
- Sequences bucket rotation for the time-decaying bloom filter.
- On each periodic `update` pulse from the watchdog timer:
  - advances the insert bucket index;
  - sweeps the oldest bucket to zero, one word per memory handshake.
- Sits between the watchdog and the bloom filter memory write port.
- Counts update pulses that arrive while a rotation is still in progress.

Parameters:
- NUM_BUCKETS, 4, number of buckets in the filter; must be >= 2.
- BUCKET_ADDR_BITS, 10, word address width inside one bucket; one bucket holds 2^BUCKET_ADDR_BITS words.
- BUCKET_BITS, log2(NUM_BUCKETS), derived localparam; minimum 1.

Ports:
- clk  in  1  single clock domain.
- reset  in  1  asynchronous, active-low reset.
- update  in  1  one-cycle rotation request pulse from the watchdog.
- enable  in  1  rotation enable; when 0, update pulses are ignored in IDLE.
- cur_bucket  out  BUCKET_BITS  bucket currently receiving inserts.
- clr_req  out  1  clear-write request to memory.
- clr_bucket  out  BUCKET_BITS  bucket being cleared.
- clr_addr  out  BUCKET_ADDR_BITS  word address being cleared.
- clr_ack  in  1  memory accepted the clear write at clr_addr this cycle.
- busy  out  1  rotation/clear in progress.
- rotate_done  out  1  one-cycle pulse when the sweep completes.
- missed_count  out  8  saturating count of dropped update pulses.

Behaviour:
- Reset (reset=0, asynchronous): all outputs are forced to 0 and state goes to IDLE.
  - This covers cur_bucket, clr_req, clr_bucket, clr_addr, busy, rotate_done and missed_count.
  - A sweep in progress is abandoned and does not resume after release.
- States: IDLE, ROTATE, CLEAR, DONE. State and all outputs are registered.
- IDLE:
  - update=1 and enable=1 at an edge: state becomes ROTATE, busy becomes 1.
  - update=1 and enable=0: ignored and not counted.
- ROTATE (exactly 1 cycle):
  - cur_bucket becomes (cur_bucket+1) mod NUM_BUCKETS; NUM_BUCKETS-1 wraps to 0.
  - clr_bucket becomes (new cur_bucket+1) mod NUM_BUCKETS, i.e. the oldest bucket.
  - clr_addr becomes 0, clr_req becomes 1, state becomes CLEAR.
- CLEAR:
  - clr_req stays 1; clr_addr and clr_bucket hold until clr_ack=1.
  - On clr_ack=1 with clr_addr < 2^BUCKET_ADDR_BITS-1: clr_addr increments.
  - On clr_ack=1 with clr_addr = 2^BUCKET_ADDR_BITS-1:
    - clr_req becomes 0, clr_addr becomes 0;
    - rotate_done becomes 1, state becomes DONE.
- DONE (1 cycle): rotate_done returns to 0, busy becomes 0, state becomes IDLE.
- Latency:
  - update sampled at edge T: busy=1 after T, cur_bucket new after T+1, clr_req=1 after T+1.
  - With clr_ack held high, the last ack is at edge T+1+2^BUCKET_ADDR_BITS.
  - rotate_done is high for the following cycle; busy=0 one cycle later.
- Missed updates:
  - update=1 in ROTATE, CLEAR or DONE increments missed_count regardless of enable.
  - missed_count saturates at 255; the pulse is not queued.
- clr_ack outside CLEAR: ignored.
- enable deasserted mid-rotation: the current rotation completes; later updates in IDLE are ignored.
- update coinciding with the final clr_ack: counted as missed, since state is still CLEAR.
- cur_bucket never equals clr_bucket while clr_req=1.

Test Plan (NUM_BUCKETS=4, BUCKET_ADDR_BITS=3):
1. Reset release, single update pulse, clr_ack tied 1:
   - cur_bucket 0->1, clr_bucket=2;
   - clr_addr steps 0..7 over 8 consecutive cycles with clr_req=1;
   - rotate_done pulses once, busy falls one cycle later.
2. Four successive rotations, each issued after busy=0:
   - cur_bucket sequence 1,2,3,0;
   - clr_bucket sequence 2,3,0,1.
3. Back-pressure, clr_ack toggled 1-0-1-0:
   - clr_addr advances only on ack cycles and holds its value on non-ack cycles;
   - the sweep takes 16 cycles; all 8 addresses are issued exactly once.
4. Update pulses during CLEAR (3 pulses) and with enable=0 in IDLE (2 pulses):
   - missed_count=3;
   - no extra rotation; cur_bucket unchanged by the ignored pulses.
5. 300 update pulses while the sweep is stalled (clr_ack=0):
   - missed_count saturates at 255 and does not wrap.
6. reset asserted asynchronously mid-CLEAR at clr_addr=4:
   - all outputs go to 0 immediately, without waiting for a clock edge;
   - after release, the next update yields cur_bucket=1, clr_bucket=2, clr_addr starting at 0.
